// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - register-file operand fetch controller with one-entry writeback buffer and forwarding
module regfile_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        start_ready,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        need_rs,
    input  logic        need_rt,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_valid,
    input  logic        op_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    output logic        rf_oe1,
    output logic        rf_oe2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    state_t      state;
    logic        pending;
    logic        wb_accept;
    logic [31:0] next_a;
    logic [31:0] next_b;

    assign wb_ready  = !pending;
    assign wb_accept = wb_valid && !pending;

    // rf_waddr/rf_wdata double as the write buffer; rf_oe/rf_raddr hold the captured request during READ
    always_comb begin
        next_a = '0;
        if (rf_oe1 && rf_raddr1 != 5'd0) begin
            if (wb_accept && wb_addr == rf_raddr1)
                next_a = wb_data;
            else if (pending && rf_waddr == rf_raddr1)
                next_a = rf_wdata;
            else
                next_a = rf_rdata1;
        end
    end

    always_comb begin
        next_b = '0;
        if (rf_oe2 && rf_raddr2 != 5'd0) begin
            if (wb_accept && wb_addr == rf_raddr2)
                next_b = wb_data;
            else if (pending && rf_waddr == rf_raddr2)
                next_b = rf_wdata;
            else
                next_b = rf_rdata2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            op_valid    <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            rf_raddr1   <= '0;
            rf_raddr2   <= '0;
            rf_oe1      <= 1'b0;
            rf_oe2      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= READ;
                        start_ready <= 1'b0;
                        rf_raddr1   <= rs;
                        rf_raddr2   <= rt;
                        rf_oe1      <= need_rs;
                        rf_oe2      <= need_rt;
                    end
                end
                READ: begin
                    state     <= HOLD;
                    op_a      <= next_a;
                    op_b      <= next_b;
                    op_valid  <= 1'b1;
                    rf_raddr1 <= '0;
                    rf_raddr2 <= '0;
                    rf_oe1    <= 1'b0;
                    rf_oe2    <= 1'b0;
                end
                HOLD: begin
                    if (op_ready) begin
                        state       <= IDLE;
                        op_valid    <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    op_valid    <= 1'b0;
                end
            endcase
        end
    end

    // r0 writes are accepted and occupy the buffer for a cycle but never strobe rf_we
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            pending <= wb_accept;
            rf_we   <= wb_accept && (wb_addr != 5'd0);
            if (wb_accept) begin
                rf_waddr <= wb_addr;
                rf_wdata <= wb_data;
            end
        end
    end

endmodule
